bank_arb_resp_demux: RTL and testbench
======================================

Name: bank_arb_resp_demux

Overview:
Bank-side counterpart of the per-master address decoder / response mux in the TCDM full crossbar. One instance sits in front of each memory bank. It arbitrates round-robin among NumIn masters, forwards the winning request to the bank, and tracks the winner's index through a RespLat-deep pipeline. That tracking steers the response-valid back to the originating master.

Parameters:
NumIn, 32, number of requesting masters (>0)
ReqDataWidth, 32, request payload width (addr/wdata/be, packed by the user)
RespDataWidth, 32, response data width
RespLat, 1, bank read latency in cycles (>0)
WriteRespOn, 1, 1: writes also produce a vld response; 0: only reads do

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumIn  per-master request
wen_i  in  NumIn  per-master write enable
data_i  in  NumIn x ReqDataWidth  per-master request payload
gnt_o  out  NumIn  per-master grant (at most one hot)
vld_o  out  NumIn  per-master response valid (at most one hot)
rdata_o  out  NumIn x RespDataWidth  per-master response data
req_o  out  1  request to bank
wen_o  out  1  write enable to bank
data_o  out  ReqDataWidth  payload to bank
gnt_i  in  1  grant from bank
rdata_i  in  RespDataWidth  bank response data

Behaviour:
- Single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset state: rr_q=0, all vld/idx pipeline stages=0. Hence vld_o=0 out of reset; gnt_o=0 and req_o=0 while no req_i is set.
- Arbitration (combinational):
  - sel = first index i with req_i[i]=1, searching cyclically from rr_q upward.
  - req_o = |req_i.
  - wen_o = wen_i[sel]; data_o = data_i[sel]. When req_o=0, these are don't-care but must be X-free.
- Grant: gnt_o[sel] = req_o & gnt_i; all other gnt_o bits are 0. Same-cycle, zero-latency handshake.
- Pointer, rr_q (width max(1,$clog2(NumIn))):
  - On handshake (req_o & gnt_i): rr_q <= (sel+1) mod NumIn, wrapping from NumIn-1 to 0. NumIn need not be a power of two.
  - No handshake (gnt_i=0 or no requests): rr_q holds. A stalled winner that keeps requesting stays the winner.
- Response pipeline: RespLat stages of {vld, idx}.
  - Stage 0 input: vld = req_o & gnt_i & (~wen_o | WriteRespOn); idx = sel.
  - Each stage shifts every cycle; there is no backpressure on responses.
  - vld_o[idx_last] = vld_last; all other vld_o bits are 0.
  - Back-to-back handshakes produce back-to-back one-hot vld_o, one per cycle, in grant order.
- rdata_o: rdata_i is broadcast to all NumIn entries. Only the entry with vld_o set is meaningful.
- NumIn==1: pure passthrough. gnt_o[0] = req_i[0] & gnt_i; no pointer logic. The vld pipeline still applies, with idx fixed at 0.
- Reset mid-operation: all in-flight responses are dropped (vld_o=0 from reset assertion on). rr_q returns to 0.
- Simultaneous requests: exactly one grant per cycle; no master starves. With K continuous requesters, each is granted at least once every K handshakes.
- Assertions (simulation only):
  - fatal if RespLat==0 or NumIn==0;
  - gnt_o is onehot0;
  - vld_o is onehot0;
  - gnt_o[i] implies req_i[i].

Test Plan:
- Reset, NumIn=4, RespLat=2: hold rst_ni low with req_i=4'b1111 and gnt_i=1. Required: vld_o=0 during reset. After release, first grant goes to master 0 (gnt_o=4'b0001).
- Single read, NumIn=4, RespLat=2: req_i=4'b0100, wen_i=0, gnt_i=1, rdata_i=32'hCAFE0002 two cycles later. Required: gnt_o=4'b0100 in the same cycle; vld_o=4'b0100 exactly 2 cycles later; rdata_o[2]=32'hCAFE0002.
- Fairness: req_i=4'b1111 held, gnt_i=1 for 6 cycles. Required: gnt_o sequence 0001,0010,0100,1000,0001,0010.
- Bank stall: req_i=4'b1010, gnt_i=0 for 3 cycles, then 1. Required: gnt_o=0 and no vld_o during the stall; rr_q unchanged. Grants then go to master 1, then master 3. data_o equals data_i[1] throughout the stall.
- Write response, run twice with req_i=4'b0001, wen_i=1, gnt_i=1, RespLat=1. With WriteRespOn=1: vld_o=4'b0001 one cycle later. With WriteRespOn=0: vld_o stays 0.
- Pipelined responses with reset: NumIn=3, RespLat=3, masters 0,1,2 granted in consecutive cycles. Required: vld_o=001,010,100 on cycles 3,4,5. Asserting rst_ni low at cycle 4 forces vld_o=0 immediately, and no later vld occurs.

Source files
------------

// File: rtl/bank_arb_resp_demux.sv
// bank_arb_resp_demux: round-robin arbiter in front of one memory bank. It tracks
//   each winner through a RespLat-deep {vld, idx} pipeline and steers the bank response
//   back to that winner.
// Latency: grant is combinational (same cycle as gnt_i); vld_o arrives RespLat cycles
//   after the handshake.
// Backpressure: gnt_i=0 stalls the current winner, and the pointer holds. Responses
//   cannot be stalled.
// Ports: req_i/wen_i/data_i come in from the masters and gnt_o goes back to them.
//   req_o/wen_o/data_o go to the bank and gnt_i comes back from it. rdata_i is broadcast
//   on rdata_o, and vld_o is one-hot to the master that issued the request.
module bank_arb_resp_demux #(
  parameter int unsigned NumIn         = 32,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter bit          WriteRespOn   = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0]                       wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]     data_i,
  output logic [NumIn-1:0]                       gnt_o,
  output logic [NumIn-1:0]                       vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]    rdata_o,
  output logic                                   req_o,
  output logic                                   wen_o,
  output logic [ReqDataWidth-1:0]                data_o,
  input  logic                                   gnt_i,
  input  logic [RespDataWidth-1:0]               rdata_i
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  typedef logic [IdxW-1:0] idx_t;

  idx_t                   rr_q;
  idx_t                   sel;
  logic [IdxW:0]          pos;
  logic                   hs;
  logic                   vld_in;
  logic [RespLat-1:0]     vld_q;
  idx_t [RespLat-1:0]     idx_q;

  // Scan from the farthest cyclic position down to rr_q. The last hit overwrites
  // earlier ones, so the requester nearest at-or-above rr_q wins. The extra bit on
  // pos absorbs rr_q+k before it is folded back, because NumIn need not be a power
  // of two.
  always_comb begin
    sel = '0;
    pos = '0;
    for (int k = int'(NumIn) - 1; k >= 0; k--) begin
      pos = {1'b0, rr_q} + (IdxW+1)'(k);
      if (pos >= (IdxW+1)'(NumIn)) pos = pos - (IdxW+1)'(NumIn);
      if (req_i[pos[IdxW-1:0]]) sel = pos[IdxW-1:0];
    end
  end

  assign req_o  = |req_i;
  assign hs     = req_o & gnt_i;
  // sel defaults to 0 when nothing requests, so the muxed outputs stay X-free.
  assign wen_o  = wen_i[sel];
  assign data_o = data_i[sel];

  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = hs;
  end

  generate
    if (NumIn == 1) begin : g_single
      assign rr_q = '0;
    end else begin : g_rr
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rr_q <= '0;
        end else if (hs) begin
          rr_q <= (sel == idx_t'(NumIn - 1)) ? '0 : sel + idx_t'(1);
        end
      end
    end
  endgenerate

  // Writes only enter the response pipe when WriteRespOn is set.
  assign vld_in = hs & (~wen_o | WriteRespOn);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= vld_in;
      idx_q[0] <= sel;
      for (int s = 1; s < int'(RespLat); s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  always_comb begin
    vld_o                      = '0;
    vld_o[idx_q[RespLat-1]]    = vld_q[RespLat-1];
  end

  assign rdata_o = {NumIn{rdata_i}};

  param_ok_a: assert property (@(posedge clk_i) (NumIn > 0) && (RespLat > 0))
    else $fatal(1, "bank_arb_resp_demux: NumIn and RespLat must be > 0");
  gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o))
    else $error("gnt_o not onehot0");
  vld_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(vld_o))
    else $error("vld_o not onehot0");
  gnt_req_a: assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0)
    else $error("gnt_o without req_i");

endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// Bench for bank_arb_resp_demux. Three configurations run side by side:
//   u=0: NumIn=4, RespLat=2, WriteRespOn=1
//   u=1: NumIn=3, RespLat=3, WriteRespOn=1
//   u=2: NumIn=1, RespLat=1, WriteRespOn=0
module tb_bank_arb_resp_demux;

  localparam int NIN [3] = '{4, 3, 1};
  localparam int RL  [3] = '{2, 3, 1};
  localparam int WR  [3] = '{1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_s  [3];
  logic [3:0]       req_s  [3];
  logic [3:0]       wen_s  [3];
  logic [3:0][31:0] dat_s  [3];
  logic             gnt_s  [3];
  logic [31:0]      rdat_s [3];

  logic [3:0]       gnt_w   [3];
  logic [3:0]       vld_w   [3];
  logic             reqo_w  [3];
  logic             weno_w  [3];
  logic [31:0]      datao_w [3];
  logic [3:0][31:0] rdata_w [3];

  logic [3:0]       a_gnt, a_vld;
  logic [3:0][31:0] a_rdata;
  logic             a_req, a_wen;
  logic [31:0]      a_data;
  logic [2:0]       b_gnt, b_vld;
  logic [2:0][31:0] b_rdata;
  logic             b_req, b_wen;
  logic [31:0]      b_data;
  logic [0:0]       c_gnt, c_vld;
  logic [0:0][31:0] c_rdata;
  logic             c_req, c_wen;
  logic [31:0]      c_data;

  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32),
                        .RespLat(2), .WriteRespOn(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_s[0]), .req_i(req_s[0]), .wen_i(wen_s[0]),
    .data_i(dat_s[0]), .gnt_o(a_gnt), .vld_o(a_vld), .rdata_o(a_rdata),
    .req_o(a_req), .wen_o(a_wen), .data_o(a_data), .gnt_i(gnt_s[0]),
    .rdata_i(rdat_s[0]));

  bank_arb_resp_demux #(.NumIn(3), .ReqDataWidth(32), .RespDataWidth(32),
                        .RespLat(3), .WriteRespOn(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_s[1]), .req_i(req_s[1][2:0]), .wen_i(wen_s[1][2:0]),
    .data_i(dat_s[1][2:0]), .gnt_o(b_gnt), .vld_o(b_vld), .rdata_o(b_rdata),
    .req_o(b_req), .wen_o(b_wen), .data_o(b_data), .gnt_i(gnt_s[1]),
    .rdata_i(rdat_s[1]));

  bank_arb_resp_demux #(.NumIn(1), .ReqDataWidth(32), .RespDataWidth(32),
                        .RespLat(1), .WriteRespOn(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_s[2]), .req_i(req_s[2][0:0]), .wen_i(wen_s[2][0:0]),
    .data_i(dat_s[2][0:0]), .gnt_o(c_gnt), .vld_o(c_vld), .rdata_o(c_rdata),
    .req_o(c_req), .wen_o(c_wen), .data_o(c_data), .gnt_i(gnt_s[2]),
    .rdata_i(rdat_s[2]));

  assign gnt_w[0] = a_gnt;            assign gnt_w[1] = {1'b0, b_gnt};
  assign gnt_w[2] = {3'b0, c_gnt};    assign vld_w[0] = a_vld;
  assign vld_w[1] = {1'b0, b_vld};    assign vld_w[2] = {3'b0, c_vld};
  assign reqo_w[0] = a_req;  assign reqo_w[1] = b_req;  assign reqo_w[2] = c_req;
  assign weno_w[0] = a_wen;  assign weno_w[1] = b_wen;  assign weno_w[2] = c_wen;
  assign datao_w[0] = a_data; assign datao_w[1] = b_data; assign datao_w[2] = c_data;
  assign rdata_w[0] = a_rdata;
  assign rdata_w[1] = {32'h0, b_rdata};
  assign rdata_w[2] = {96'h0, c_rdata};

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(input int u, input string nm,
                                input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got %0h, expected %0h (t=%0t)", u, nm, act, exp, $time);
  endfunction

  // Reference model: a pointer and a per-cycle list of which master's response is
  // in flight (-1 = none). Outputs are compared on every falling edge, and the state
  // then advances as the coming rising edge will.
  int rr_m   [3];
  int pipe_m [3][4];

  task automatic model_cycle(input int u);
    int n, sel, hit, j;
    logic [3:0] eg, ev;
    n = NIN[u];
    if (!rst_s[u]) begin
      rr_m[u] = 0;
      for (int k = 0; k < 4; k++) pipe_m[u][k] = -1;
    end
    sel = -1;
    for (int k = 0; k < n; k++) begin
      j = (rr_m[u] + k) % n;
      if (sel < 0 && req_s[u][j]) sel = j;
    end
    eg  = (sel >= 0 && gnt_s[u]) ? 4'(1 << sel) : 4'h0;
    hit = pipe_m[u][RL[u]-1];
    ev  = (hit >= 0) ? 4'(1 << hit) : 4'h0;
    check(u, "m_gnt", 64'(gnt_w[u]), 64'(eg));
    check(u, "m_vld", 64'(vld_w[u]), 64'(ev));
    check(u, "m_req_o", 64'(reqo_w[u]), 64'(sel >= 0));
    if (sel >= 0) begin
      check(u, "m_wen_o", 64'(weno_w[u]), 64'(wen_s[u][sel]));
      check(u, "m_data_o", 64'(datao_w[u]), 64'(dat_s[u][sel]));
    end
    if (hit >= 0) check(u, "m_rdata", 64'(rdata_w[u][hit]), 64'(rdat_s[u]));
    if (rst_s[u]) begin
      for (int k = 3; k > 0; k--) pipe_m[u][k] = pipe_m[u][k-1];
      pipe_m[u][0] = (sel >= 0 && gnt_s[u] && (!wen_s[u][sel] || WR[u] != 0)) ? sel : -1;
      if (sel >= 0 && gnt_s[u]) rr_m[u] = (sel + 1) % n;
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) model_cycle(u);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fair [6];

  initial begin
    fair = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int u = 0; u < 3; u++) begin
      req_s[u] = '0; wen_s[u] = '0; gnt_s[u] = 1'b0;
      dat_s[u] = '0; rdat_s[u] = '0; rst_s[u] = 1'b1;
    end
    #1;
    for (int u = 0; u < 3; u++) rst_s[u] = 1'b0;

    // Reset held with all requests pending: no responses.
    req_s[0] = 4'hF; gnt_s[0] = 1'b1;
    for (int m = 0; m < 4; m++) dat_s[0][m] = 32'h1000 + m;
    step();
    repeat (3) begin #2; check(0, "rst_vld", 64'(vld_w[0]), 64'h0); step(); end

    // Release, then fairness with all four requesting.
    for (int u = 0; u < 3; u++) rst_s[u] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2; check(0, "fair_gnt", 64'(gnt_w[0]), 64'(fair[i])); step();
    end
    req_s[0] = '0;
    repeat (3) step();

    // Single read from master 2; the response comes two cycles later.
    req_s[0] = 4'b0100; wen_s[0] = '0;
    #2; check(0, "rd_gnt", 64'(gnt_w[0]), 64'b0100); step();
    req_s[0] = '0;
    #2; check(0, "rd_vld_early", 64'(vld_w[0]), 64'h0); step();
    rdat_s[0] = 32'hCAFE0002;
    #2; check(0, "rd_vld", 64'(vld_w[0]), 64'b0100);
    check(0, "rd_data", 64'(rdata_w[0][2]), 64'hCAFE0002); step();

    // Write from master 0 with write responses enabled.
    req_s[0] = 4'b0001; wen_s[0] = 4'b0001;
    #2; check(0, "wr_gnt", 64'(gnt_w[0]), 64'b0001); step();
    req_s[0] = '0; wen_s[0] = '0;
    #2; check(0, "wr_vld_early", 64'(vld_w[0]), 64'h0); step();
    #2; check(0, "wr_vld", 64'(vld_w[0]), 64'b0001); step();

    // Bank stall: the pointer sits at 1, so master 1 is the stalled winner.
    req_s[0] = 4'b1010; gnt_s[0] = 1'b0;
    for (int m = 0; m < 4; m++) dat_s[0][m] = 32'hD000 + m;
    repeat (3) begin
      #2; check(0, "stall_gnt", 64'(gnt_w[0]), 64'h0);
      check(0, "stall_data", 64'(datao_w[0]), 64'hD001);
      check(0, "stall_vld", 64'(vld_w[0]), 64'h0); step();
    end
    gnt_s[0] = 1'b1;
    #2; check(0, "stall_gnt1", 64'(gnt_w[0]), 64'b0010); step();
    #2; check(0, "stall_gnt3", 64'(gnt_w[0]), 64'b1000); step();
    req_s[0] = '0;
    repeat (3) step();

    // Three-master pipeline, RespLat=3, reset lands mid-flight.
    gnt_s[1] = 1'b1; wen_s[1] = '0;
    for (int i = 0; i < 3; i++) begin
      req_s[1] = 4'(1 << i);
      #2; check(1, "pipe_gnt", 64'(gnt_w[1]), 64'(4'(1 << i))); step();
    end
    req_s[1] = '0;
    #2; check(1, "pipe_vld0", 64'(vld_w[1]), 64'b001); step();
    rst_s[1] = 1'b0;
    #2; check(1, "pipe_rst_vld", 64'(vld_w[1]), 64'h0); step();
    rst_s[1] = 1'b1;
    repeat (4) begin #2; check(1, "pipe_after_rst", 64'(vld_w[1]), 64'h0); step(); end

    // Single-master passthrough, write responses disabled.
    gnt_s[2] = 1'b1; req_s[2] = 4'b0001; wen_s[2] = 4'b0001;
    #2; check(2, "c_gnt", 64'(gnt_w[2]), 64'h1); step();
    wen_s[2] = '0;
    #2; check(2, "c_wr_novld", 64'(vld_w[2]), 64'h0); step();
    req_s[2] = '0;
    #2; check(2, "c_rd_vld", 64'(vld_w[2]), 64'h1); step();
    req_s[2] = 4'b0001; gnt_s[2] = 1'b0;
    #2; check(2, "c_stall_gnt", 64'(gnt_w[2]), 64'h0); step();

    // Randomized traffic, with occasional single-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      for (int u = 0; u < 3; u++) begin
        req_s[u] = ($urandom_range(0, 3) == 0) ? 4'h0
                   : (4'($urandom) & 4'((1 << NIN[u]) - 1));
        wen_s[u] = 4'($urandom);
        gnt_s[u] = ($urandom_range(0, 3) != 0);
        for (int m = 0; m < 4; m++) dat_s[u][m] = $urandom;
        rdat_s[u] = $urandom;
        rst_s[u] = ($urandom_range(0, 199) != 0);
      end
      step();
    end
    for (int u = 0; u < 3; u++) begin req_s[u] = '0; rst_s[u] = 1'b1; end
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
